// File: rtl/ponylink_enc_8b10b.sv
// 8b/10b line encoder for the PonyLink packer stream; fills empty slots with K28.5.
// Define PONYLINK_ENC_COMMA_INSERT_EN to force a K28.5 after COMMA_PERIOD consecutive non-comma symbols.
module ponylink_enc_8b10b #(
  parameter int unsigned COMMA_PERIOD = 256
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [8:0] ser_tdata,
  input  logic       ser_tvalid,
  output logic       ser_tready,
  input  logic       sym_ready,
  output logic [9:0] sym_data,
  output logic       sym_rd,
  output logic       code_err
);

  localparam logic [7:0] K28_5 = 8'hBC;

  logic       force_comma;
  logic       k_legal;
  logic       bad_k;
  logic       use_idle;
  logic       enc_k;
  logic [7:0] enc_byte;
  logic [4:0] x5;
  logic [2:0] y3;
  logic [5:0] c6_n;
  logic [5:0] c6;
  logic [3:0] c4_n;
  logic [3:0] c4;
  logic       rd6;
  logic       alt7;
  logic       enc_rd;
  logic [9:0] code_w;
  logic [9:0] enc_sym;
  logic [9:0] sym_data_q;
  logic       sym_rd_q;
  logic       code_err_q;

  if (COMMA_PERIOD < 2 || COMMA_PERIOD > 65535) begin : g_bad_period
    $error("COMMA_PERIOD must lie in 2..65535");
  end

  assign ser_tready = resetn && sym_ready && !force_comma;
  assign k_legal    = (ser_tdata[4:0] == 5'd28) ||
                      (ser_tdata[7:0] inside {8'hF7, 8'hFB, 8'hFD, 8'hFE});
  assign bad_k      = ser_tvalid && ser_tdata[8] && !k_legal && !force_comma;
  assign use_idle   = force_comma || !ser_tvalid || bad_k;
  assign enc_k      = use_idle || ser_tdata[8];
  assign enc_byte   = use_idle ? K28_5 : ser_tdata[7:0];
  assign x5         = enc_byte[4:0];
  assign y3         = enc_byte[7:5];

  // 5b/6b RD- column, written abcdei with a in the MSB.
  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    c6_n = 6'b000000;
    case (x5)
      5'd0:  c6_n = 6'b100111;  5'd1:  c6_n = 6'b011101;
      5'd2:  c6_n = 6'b101101;  5'd3:  c6_n = 6'b110001;
      5'd4:  c6_n = 6'b110101;  5'd5:  c6_n = 6'b101001;
      5'd6:  c6_n = 6'b011001;  5'd7:  c6_n = 6'b111000;
      5'd8:  c6_n = 6'b111001;  5'd9:  c6_n = 6'b100101;
      5'd10: c6_n = 6'b010101;  5'd11: c6_n = 6'b110100;
      5'd12: c6_n = 6'b001101;  5'd13: c6_n = 6'b101100;
      5'd14: c6_n = 6'b011100;  5'd15: c6_n = 6'b010111;
      5'd16: c6_n = 6'b011011;  5'd17: c6_n = 6'b100011;
      5'd18: c6_n = 6'b010011;  5'd19: c6_n = 6'b110010;
      5'd20: c6_n = 6'b001011;  5'd21: c6_n = 6'b101010;
      5'd22: c6_n = 6'b011010;  5'd23: c6_n = 6'b111010;
      5'd24: c6_n = 6'b110011;  5'd25: c6_n = 6'b100110;
      5'd26: c6_n = 6'b010110;  5'd27: c6_n = 6'b110110;
      5'd28: c6_n = 6'b001110;  5'd29: c6_n = 6'b101110;
      5'd30: c6_n = 6'b011110;  5'd31: c6_n = 6'b101011;
      default: c6_n = 6'b000000;
    endcase
    if (enc_k && x5 == 5'd28) c6_n = 6'b001111;
  end

  // D7 is balanced but still has a distinct RD+ form.
  assign c6  = (sym_rd_q && (($countones(c6_n) != 3) || x5 == 5'd7)) ? ~c6_n : c6_n;
  assign rd6 = sym_rd_q ^ ($countones(c6_n) != 3);

  assign alt7 = (!rd6 && (x5 inside {5'd17, 5'd18, 5'd20})) ||
                ( rd6 && (x5 inside {5'd11, 5'd13, 5'd14}));

  always_comb begin
    c4_n = 4'b0000;
    if (enc_k) begin
      case (y3)
        3'd0: c4_n = 4'b1011;  3'd1: c4_n = 4'b0110;
        3'd2: c4_n = 4'b1010;  3'd3: c4_n = 4'b1100;
        3'd4: c4_n = 4'b1101;  3'd5: c4_n = 4'b0101;
        3'd6: c4_n = 4'b1001;  3'd7: c4_n = 4'b0111;
        default: c4_n = 4'b0000;
      endcase
    end else begin
      case (y3)
        3'd0: c4_n = 4'b1011;  3'd1: c4_n = 4'b1001;
        3'd2: c4_n = 4'b0101;  3'd3: c4_n = 4'b1100;
        3'd4: c4_n = 4'b1101;  3'd5: c4_n = 4'b1010;
        3'd6: c4_n = 4'b0110;  3'd7: c4_n = alt7 ? 4'b0111 : 4'b1110;
        default: c4_n = 4'b0000;
      endcase
    end
  end

  // Every K 4b code has a distinct RD+ form, as does the balanced D.x.3.
  assign c4     = (rd6 && (enc_k || ($countones(c4_n) != 2) || y3 == 3'd3)) ? ~c4_n : c4_n;
  assign enc_rd = rd6 ^ ($countones(c4_n) != 2);
  assign code_w = {c6, c4};

  // Tables are written a-first; the line wants a in bit 0.
  always_comb begin
    enc_sym = '0;
    for (int i = 0; i < 10; i++) enc_sym[i] = code_w[9 - i];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      sym_data_q <= 10'h17C;
      sym_rd_q   <= 1'b1;
      code_err_q <= 1'b0;
    end else if (sym_ready) begin
      sym_data_q <= enc_sym;
      sym_rd_q   <= enc_rd;
      code_err_q <= bad_k;
    end else begin
      code_err_q <= 1'b0;
    end
  end

`ifdef PONYLINK_ENC_COMMA_INSERT_EN
  logic [15:0] comma_cnt_q;
  logic [15:0] comma_cnt_d;

  assign force_comma = (comma_cnt_q == 16'(COMMA_PERIOD));

  always_comb begin
    comma_cnt_d = comma_cnt_q;
    if (sym_ready) comma_cnt_d = (enc_k && enc_byte == K28_5) ? 16'd0 : comma_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) comma_cnt_q <= 16'd0;
    else         comma_cnt_q <= comma_cnt_d;
  end
`else
  assign force_comma = 1'b0;
`endif

  assign sym_data = sym_data_q;
  assign sym_rd   = sym_rd_q;
  assign code_err = code_err_q;

endmodule

// File: tb/tb_ponylink_enc_8b10b.sv
// Bench for ponylink_enc_8b10b: directed cases plus a random stream checked against
// a table-driven 8b/10b reference built from the standard two-column code tables.
module tb_ponylink_enc_8b10b;

  localparam int unsigned TB_PERIOD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] ser_tdata = 9'd0;
  logic       ser_tvalid = 1'b0;
  logic       sym_ready = 1'b0;
  logic       ser_tready;
  logic [9:0] sym_data;
  logic       sym_rd;
  logic       code_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] m_data = 10'h17C;
  logic       m_rd   = 1'b1;
  logic       m_err  = 1'b0;
  int         m_run  = 0;

  ponylink_enc_8b10b #(.COMMA_PERIOD(TB_PERIOD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_tdata (ser_tdata),
    .ser_tvalid(ser_tvalid),
    .ser_tready(ser_tready),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .sym_rd    (sym_rd),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  // Standard code tables, RD- and RD+ columns, written abcdei / fghj.
  logic [5:0] t6_neg [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] t6_pos [0:31] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] t4d_neg [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4d_pos [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] t4k_neg [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] t4k_pos [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] k_list  [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal_k(input logic [7:0] b);
    logic hit = 1'b0;
    for (int i = 0; i < 12; i++) if (k_list[i] == b) hit = 1'b1;
    return hit;
  endfunction

  // Returns {rd_after, symbol}; symbol bit 0 is a.
  function automatic logic [10:0] ref_encode(input logic k, input logic [7:0] b, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six;
    logic [3:0] four;
    logic       rd_mid;
    logic       alt;
    logic [9:0] s;
    int         ones;
    logic       rd_out;
    x = b[4:0];
    y = b[7:5];
    if (k && x == 5'd28) six = rd ? 6'b110000 : 6'b001111;
    else                 six = rd ? t6_pos[x] : t6_neg[x];
    rd_mid = ($countones(six) == 4) ? 1'b1 : ($countones(six) == 2) ? 1'b0 : rd;
    alt = (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          ( rd && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (k)                      four = rd_mid ? t4k_pos[y] : t4k_neg[y];
    else if (y == 3'd7 && alt)  four = rd_mid ? 4'b1000 : 4'b0111;
    else                        four = rd_mid ? t4d_pos[y] : t4d_neg[y];
    s = {four[0], four[1], four[2], four[3], six[0], six[1], six[2], six[3], six[4], six[5]};
    ones = $countones(s);
    rd_out = (ones == 6) ? 1'b1 : (ones == 4) ? 1'b0 : rd;
    return {rd_out, s};
  endfunction

  function automatic logic model_force();
`ifdef PONYLINK_ENC_COMMA_INSERT_EN
    return m_run == int'(TB_PERIOD);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [8:0] rand_sym();
    int r = $urandom_range(0, 9);
    if (r < 7) return {1'b0, 8'($urandom)};
    if (r < 9) return {1'b1, k_list[$urandom_range(0, 11)]};
    return {1'b1, 8'($urandom)};
  endfunction

  // One clock: drive, check ready at negedge, advance model at posedge, check outputs after.
  task automatic cycle(input logic rst_i, input logic rdy, input logic vld,
                       input logic [8:0] d, output logic accepted);
    logic        exp_tready;
    logic        fc;
    logic        bad;
    logic        comma;
    logic [10:0] e;
    resetn     = rst_i;
    sym_ready  = rdy;
    ser_tvalid = vld;
    ser_tdata  = d;
    @(negedge clk);
    fc = model_force();
    exp_tready = rst_i && rdy && !fc;
    check("ser_tready", ser_tready, exp_tready);
    accepted = exp_tready && vld;
    @(posedge clk);
    if (!rst_i) begin
      m_data = 10'h17C; m_rd = 1'b1; m_err = 1'b0; m_run = 0;
    end else if (rdy) begin
      bad   = vld && d[8] && !is_legal_k(d[7:0]) && !fc;
      comma = fc || !vld || bad;
      e     = comma ? ref_encode(1'b1, 8'hBC, m_rd) : ref_encode(d[8], d[7:0], m_rd);
      m_data = e[9:0];
      m_rd   = e[10];
      m_err  = bad;
      if (comma || (d[8] && d[7:0] == 8'hBC)) m_run = 0;
      else                                     m_run++;
    end else begin
      m_err = 1'b0;
    end
    #1;
    check("sym_data", sym_data, m_data);
    check("sym_rd", sym_rd, m_rd);
    check("code_err", code_err, m_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic       have;
    logic       rdy;
    logic [8:0] pend;
    int         commas;
    int         exp_commas;

    cycle(1'b0, 1'b1, 1'b1, 9'h055, a);
    cycle(1'b0, 1'b1, 1'b1, 9'h055, a);
    check("rst_data", sym_data, 10'h17C);
    check("rst_rd", sym_rd, 1'b1);
    check("rst_err", code_err, 1'b0);

    cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
    check("idle0", sym_data, 10'h283);  check("idle0_rd", sym_rd, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
    check("idle1", sym_data, 10'h17C);  check("idle1_rd", sym_rd, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
    check("idle2", sym_data, 10'h283);  check("idle2_rd", sym_rd, 1'b0);

    cycle(1'b1, 1'b1, 1'b1, 9'h0B5, a);
    check("d21_5", sym_data, 10'h155);  check("d21_5_rd", sym_rd, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 9'h11C, a);
    check("k28_0", sym_data, 10'h0BC);  check("k28_0_rd", sym_rd, 1'b0);

    cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
    check("idle_to_rdp", sym_rd, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 9'h1A5, a);
    check("badk_data", sym_data, 10'h283);
    check("badk_err", code_err, 1'b1);
    check("badk_rd", sym_rd, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
    check("badk_err_clr", code_err, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 9'h0B5, a);
    check("hold_data", sym_data, 10'h17C);
    check("hold_rd", sym_rd, 1'b1);

    // Continuous D0.0 from a fresh reset.
    cycle(1'b0, 1'b0, 1'b0, 9'h000, a);
    commas = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 9'h000, a);
      if (sym_data == 10'h17C || sym_data == 10'h283) commas++;
    end
`ifdef PONYLINK_ENC_COMMA_INSERT_EN
    exp_commas = 3;
`else
    exp_commas = 0;
`endif
    check("comma_count", commas, exp_commas);

    have = 1'b0;
    pend = 9'h000;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        cycle(1'b0, 1'b1, 1'b1, pend, a);
        cycle(1'b0, 1'b1, 1'b1, pend, a);
        have = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 9'h000, a);
        check("post_rst_idle", sym_data, 10'h283);
      end
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        pend = rand_sym();
      end
      rdy = 1'($urandom_range(0, 1));
      cycle(1'b1, rdy, have, pend, a);
      if (a) have = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
